// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Decimal digits needed to show the largest unsigned value of the given width.
  function automatic int digits_needed(input int width);
    longint max_val;
    int n;
    max_val = (longint'(1) << width) - 1;
    n = 0;
    do begin
      n++;
      max_val = max_val / 10;
    end while (max_val > 0);
    return n;
  endfunction

endpackage

// File: rtl/BCDto7seg.sv
// BCD digit to seven-segment pattern, active-high, seg = {g,f,e,d,c,b,a}.
module BCDto7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/bcd_digit_adjust.sv
// Add-3 correction for one BCD digit ahead of a shift-and-add-3 shift.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter driving a bank of
// seven-segment digits, with optional signed input and leading-zero blanking.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WORD_LENGTH   = 8,
  parameter int DIGITS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   bin,
  input  logic                     signed_mode,
  output logic                     busy,
  output logic                     done,
  output logic [4*DIGITS-1:0]      bcd,
  output logic                     negative,
  output logic [7*DIGITS-1:0]      seg,
  output state_t                   fsm_state
);

  localparam int CW = $clog2(WORD_LENGTH + 1);

  if (WORD_LENGTH < 2) begin : g_bad_width
    $error("bin2bcd_seq: WORD_LENGTH must be at least 2");
  end
  if (DIGITS < digits_needed(WORD_LENGTH)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WORD_LENGTH");
  end

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic [WORD_LENGTH-1:0]  mag;
  logic                    neg_q;
  logic [4*DIGITS-1:0]     scratch;
  logic [4*DIGITS-1:0]     adj;
  logic [4*DIGITS-1:0]     scratch_next;
  logic [7*DIGITS-1:0]     seg_raw;

  // Handshake: start is honoured only in IDLE (busy=0); busy covers every SHIFT
  // cycle plus the DONE cycle; done pulses once with bcd/negative already valid.
  assign scratch_next = {adj[4*DIGITS-2:0], mag[WORD_LENGTH-1]};
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mag      <= '0;
      neg_q    <= 1'b0;
      scratch  <= '0;
      bcd      <= '0;
      negative <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mag      <= (signed_mode && bin[WORD_LENGTH-1]) ? (~bin + WORD_LENGTH'(1)) : bin;
            neg_q    <= signed_mode & bin[WORD_LENGTH-1];
            scratch  <= '0;
            cnt      <= CW'(WORD_LENGTH);
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          mag     <= {mag[WORD_LENGTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          // Results land on the last shift so they are valid during done.
          if (cnt == CW'(1)) begin
            bcd      <= scratch_next;
            negative <= neg_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .digit    (scratch[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );

    BCDto7seg u_seg (
      .bcd (bcd[4*i +: 4]),
      .seg (seg_raw[7*i +: 7])
    );

    if (i == 0) begin : g_units
      assign seg[6:0] = seg_raw[6:0];
    end else begin : g_upper
      assign seg[7*i +: 7] = (BLANK_LEADING != 0 && bcd[4*DIGITS-1:4*i] == '0)
                             ? SEG_BLANK : seg_raw[7*i +: 7];
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations share one clock and reset.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk;
  logic reset;

  logic        start_a, start_b, start_c;
  logic [7:0]  bin_a, bin_b;
  logic [11:0] bin_c;
  logic        signed_a, signed_b, signed_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [11:0] bcd_a, bcd_b;
  logic [15:0] bcd_c;
  logic        neg_a, neg_b, neg_c;
  logic [20:0] seg_a, seg_b;
  logic [27:0] seg_c;
  state_t      fsm_a, fsm_b, fsm_c;

  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  logic [63:0] exp_q_c[$];

  int n_checks;
  int n_errors;

  bin2bcd_seq #(.WORD_LENGTH(8), .DIGITS(3), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin(bin_a), .signed_mode(signed_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .negative(neg_a), .seg(seg_a),
    .fsm_state(fsm_a)
  );

  bin2bcd_seq #(.WORD_LENGTH(8), .DIGITS(3), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin(bin_b), .signed_mode(signed_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .negative(neg_b), .seg(seg_b),
    .fsm_state(fsm_b)
  );

  bin2bcd_seq #(.WORD_LENGTH(12), .DIGITS(4), .BLANK_LEADING(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .bin(bin_c), .signed_mode(signed_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .negative(neg_c), .seg(seg_c),
    .fsm_state(fsm_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference: arithmetic decimal split, packed as {neg@63, bcd@47:32, seg@27:0}.
  function automatic logic [63:0] model(input int wl, input int digits, input bit blank,
                                        input logic [11:0] v, input bit s);
    logic [63:0] r;
    int  mag;
    int  d;
    bit  neg;
    bit  hz;
    neg = s && v[wl-1];
    mag = int'(v) & ((1 << wl) - 1);
    if (neg) mag = (1 << wl) - mag;
    r = '0;
    r[63] = neg;
    hz = 1'b1;
    for (int i = digits - 1; i >= 0; i--) begin
      d = (mag / (10 ** i)) % 10;
      r[32 + 4*i +: 4] = d[3:0];
      hz = hz && (d == 0);
      r[7*i +: 7] = (blank && i > 0 && hz) ? 7'h00 : seg7(d);
    end
    return r;
  endfunction

  function automatic logic [63:0] pack_obs(input logic n, input logic [15:0] b, input logic [27:0] s);
    logic [63:0] r;
    r = '0;
    r[63] = n;
    r[32 +: 16] = b;
    r[0 +: 28] = s;
    return r;
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      check("a_done_expected", 64'(exp_q_a.size() != 0), 64'd1);
      if (exp_q_a.size() != 0)
        check("a_result", pack_obs(neg_a, {4'h0, bcd_a}, {7'h00, seg_a}), exp_q_a.pop_front());
    end
    if (done_b === 1'b1) begin
      check("b_done_expected", 64'(exp_q_b.size() != 0), 64'd1);
      if (exp_q_b.size() != 0)
        check("b_result", pack_obs(neg_b, {4'h0, bcd_b}, {7'h00, seg_b}), exp_q_b.pop_front());
    end
    if (done_c === 1'b1) begin
      check("c_done_expected", 64'(exp_q_c.size() != 0), 64'd1);
      if (exp_q_c.size() != 0)
        check("c_result", pack_obs(neg_c, bcd_c, seg_c), exp_q_c.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit done_of(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic convert(input int which, input logic [11:0] v, input bit s);
    int lat;
    int wl;
    @(negedge clk);
    case (which)
      0: begin bin_a = v[7:0]; signed_a = s; start_a = 1'b1; wl = 8;
               exp_q_a.push_back(model(8, 3, 1'b1, v, s)); end
      1: begin bin_b = v[7:0]; signed_b = s; start_b = 1'b1; wl = 8;
               exp_q_b.push_back(model(8, 3, 1'b0, v, s)); end
      default: begin bin_c = v; signed_c = s; start_c = 1'b1; wl = 12;
               exp_q_c.push_back(model(12, 4, 1'b1, v, s)); end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    lat = 1;
    while (!done_of(which) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(wl + 1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    start_a  = 1'b0; start_b  = 1'b0; start_c  = 1'b0;
    bin_a    = '0;   bin_b    = '0;   bin_c    = '0;
    signed_a = 1'b0; signed_b = 1'b0; signed_c = 1'b0;

    #1;
    check("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
    check("rst_done", {done_a, done_b, done_c}, 3'b000);
    check("rst_state", {fsm_a, fsm_b, fsm_c}, {IDLE, IDLE, IDLE});
    check("rst_bcd_neg_a", pack_obs(neg_a, {4'h0, bcd_a}, '0), 64'd0);
    check("rst_seg_a", seg_a, {SEG_BLANK, SEG_BLANK, 7'h3F});
    check("rst_seg_b", seg_b, {7'h3F, 7'h3F, 7'h3F});
    check("rst_seg_c", seg_c, {SEG_BLANK, SEG_BLANK, SEG_BLANK, 7'h3F});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Unsigned max and signed extremes
    convert(0, 12'h0FF, 1'b0);
    convert(0, 12'h080, 1'b1);
    convert(0, 12'h07F, 1'b1);
    convert(0, 12'h0FF, 1'b1);
    convert(0, 12'h000, 1'b0);
    convert(0, 12'h000, 1'b1);
    convert(0, 12'h00A, 1'b0);

    // Result holds between conversions
    repeat (5) @(posedge clk);
    #1;
    check("hold_a", pack_obs(neg_a, {4'h0, bcd_a}, {7'h00, seg_a}), model(8, 3, 1'b1, 12'h00A, 1'b0));

    // Handshake: starts during SHIFT and DONE are dropped
    @(negedge clk);
    bin_a = 8'h2A; signed_a = 1'b0; start_a = 1'b1;
    exp_q_a.push_back(model(8, 3, 1'b1, 12'h02A, 1'b0));
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    bin_a = 8'h63; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("hs_busy_mid", busy_a, 1'b1);
    begin
      int guard;
      guard = 0;
      while (!done_a && guard < 40) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("hs_done_seen", done_a, 1'b1);
    end
    start_a = 1'b1;
    bin_a = 8'h63;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("hs_drop_in_done", {busy_a, fsm_a}, {1'b0, IDLE});
    convert(0, 12'h063, 1'b0);

    // Async reset mid-conversion
    @(negedge clk);
    bin_a = 8'h55; signed_a = 1'b0; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state", fsm_a, SHIFT);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {busy_a, done_a}, 2'b00);
    check("mid_rst_state", fsm_a, IDLE);
    check("mid_rst_bcd", pack_obs(neg_a, {4'h0, bcd_a}, '0), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("after_rst_idle", busy_a, 1'b0);
    convert(0, 12'h064, 1'b0);

    // Random traffic
    for (int i = 0; i < 6; i++)
      convert(0, 12'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // No blanking configuration
    convert(1, 12'h000, 1'b0);
    convert(1, 12'h007, 1'b0);
    convert(1, 12'h0F6, 1'b1);

    // Wider configuration
    convert(2, 12'hFFF, 1'b0);
    convert(2, 12'h800, 1'b1);
    convert(2, 12'h03B, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("q_a_drained", 64'(exp_q_a.size()), 64'd0);
    check("q_b_drained", 64'(exp_q_b.size()), 64'd0);
    check("q_c_drained", 64'(exp_q_c.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
